// File: rtl/bcd_seq_adder_ctrl.sv
// bcd_seq_adder_ctrl: sequences one shared single-digit BCD adder across
// DIGITS digits, least-significant digit first, one digit per clock.
// Optional feature: define BCD_CHECK_EN to flag non-BCD operand digits on err.
module bcd_seq_adder_ctrl #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3   // needs 2**CNT_W > DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                Cin,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_s,
  input  logic                add_cout,
  output logic [4*DIGITS-1:0] s,
  output logic                Cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [W-1:0]     a_sr, b_sr, s_r;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_r;
  logic             accept, last;

  // start is only honoured outside RUN; DONE accepts it for back-to-back ops
  assign accept = start && (state != RUN);
  assign last   = (cnt == CNT_W'(DIGITS - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state and status decode from the registered state
  always_comb begin
    nxt     = state;
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        busy    = 1'b1;
        add_a   = a_sr[3:0];
        add_b   = b_sr[3:0];
        add_cin = carry;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = start ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // operand shift registers, ripple carry and result collection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_r    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      s_r    <= '0;
      cnt    <= '0;
      carry  <= Cin;
      cout_r <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < DIGITS; i++)
        if (cnt == CNT_W'(i)) s_r[4*i +: 4] <= add_s;
      a_sr  <= a_sr >> 4;
      b_sr  <= b_sr >> 4;
      carry <= add_cout;
      cnt   <= cnt + CNT_W'(1);
      if (last) cout_r <= add_cout;
    end
  end

  assign s    = s_r;
  assign Cout = cout_r;

`ifdef BCD_CHECK_EN
  logic err_r;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // invalid-digit flag, re-evaluated on every accepted start
  always_ff @(posedge clk) begin
    if (!rst_n)      err_r <= 1'b0;
    else if (accept) err_r <= has_bad_digit(a) | has_bad_digit(b);
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Directed bench for bcd_seq_adder_ctrl with a behavioural single-digit
// BCD adder wired to the controller's shared-adder ports.
module tb_bcd_seq_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n, start, Cin;
  logic [W-1:0] a, b, s;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout, Cout, busy, done, err;
  logic [4:0]   raw;

  int pass_cnt = 0;
  int total    = 0;
  logic exp_err;

  always #5 clk = ~clk;

  bcd_seq_adder_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Cin(Cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .s(s), .Cout(Cout), .busy(busy), .done(done), .err(err)
  );

  // single-digit BCD adder: binary sum, +6 correction above 9
  always_comb begin
    raw = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    if (raw > 5'd9) begin
      add_cout = 1'b1;
      add_s    = 4'(raw + 5'd6);
    end else begin
      add_cout = 1'b0;
      add_s    = raw[3:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a = va; b = vb; Cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // called in RUN cycle 1; walks the four RUN cycles then checks the done cycle
  task automatic run_and_check(input string nm, input logic [W-1:0] es, input logic ec,
                               input logic [3:0] ecins, input logic chk_cins);
    logic [3:0] cins;
    cins = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s run%0d busy=%b done=%b expected busy=1 done=0", nm, i, busy, done);
      else pass_cnt++;
      cins[i] = add_cin;
      tick();
    end
    if (chk_cins) begin
      total++;
      if (cins !== ecins) $display("FAIL %s add_cin seq=%b expected %b", nm, cins, ecins);
      else pass_cnt++;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done=%b busy=%b expected done=1 busy=0", nm, done, busy);
    else pass_cnt++;
    total++;
    if (s !== es || Cout !== ec)
      $display("FAIL %s s=%h Cout=%b expected s=%h Cout=%b", nm, s, Cout, es, ec);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Cin = 1'b0;
    tick(); tick();
    total++;
    if (s !== 16'h0 || Cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0)
      $display("FAIL reset s=%h Cout=%b busy=%b done=%b err=%b add_a=%h", s, Cout, busy, done, err, add_a);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    issue(16'h1234, 16'h5678, 1'b0);
    total++;
    if (add_a !== 4'h4 || add_b !== 4'h8)
      $display("FAIL basic first digit add_a=%h add_b=%h expected 4 8", add_a, add_b);
    else pass_cnt++;
    run_and_check("basic", 16'h6912, 1'b0, 4'b0110, 1'b1);
    tick();
    total++;
    if (done !== 1'b0 || s !== 16'h6912 || add_a !== 4'd0)
      $display("FAIL basic hold done=%b s=%h add_a=%h expected 0 6912 0", done, s, add_a);
    else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    issue(16'h9999, 16'h0001, 1'b0);
    run_and_check("carry", 16'h0000, 1'b1, 4'b1110, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    issue(16'h9999, 16'h9999, 1'b1);
    run_and_check("b2b_1", 16'h9999, 1'b1, 4'b1111, 1'b1);
    issue(16'h0005, 16'h0004, 1'b0);
    run_and_check("b2b_2", 16'h0009, 1'b0, 4'b0000, 1'b1);
    tick();
  endtask

  task automatic test_start_ignored();
    issue(16'h0250, 16'h0125, 1'b0);
    tick();                                 // RUN cycle 2
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    tick();                                 // RUN cycle 3
    start = 1'b0;
    for (int i = 2; i < DIGITS; i++) begin
      total++;
      if (busy !== 1'b1) $display("FAIL ignore busy=%b expected 1 at run%0d", busy, i);
      else pass_cnt++;
      tick();
    end
    total++;
    if (done !== 1'b1 || s !== 16'h0375 || Cout !== 1'b0)
      $display("FAIL ignore done=%b s=%h Cout=%b expected 1 0375 0", done, s, Cout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_mid_reset();
    logic seen_done;
    issue(16'h1234, 16'h5678, 1'b0);
    tick();                                 // RUN cycle 2
    tick();                                 // RUN cycle 3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (s !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || Cout !== 1'b0)
      $display("FAIL midreset s=%h busy=%b done=%b Cout=%b expected 0 0 0 0", s, busy, done, Cout);
    else pass_cnt++;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    total++;
    if (seen_done !== 1'b0) $display("FAIL midreset_quiet activity=%b expected 0", seen_done);
    else pass_cnt++;
  endtask

  task automatic test_bcd_check();
`ifdef BCD_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    issue(16'h00A0, 16'h0001, 1'b0);
    for (int i = 0; i < DIGITS; i++) tick();
    total++;
    if (done !== 1'b1 || err !== exp_err)
      $display("FAIL bcd_bad done=%b err=%b expected done=1 err=%b", done, err, exp_err);
    else pass_cnt++;
    tick();
    total++;
    if (err !== exp_err) $display("FAIL bcd_hold err=%b expected %b", err, exp_err);
    else pass_cnt++;
    issue(16'h0001, 16'h0001, 1'b0);
    run_and_check("bcd_ok", 16'h0002, 1'b0, 4'b0000, 1'b0);
    total++;
    if (err !== 1'b0) $display("FAIL bcd_clear err=%b expected 0", err);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    test_bcd_check();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
